// File: rtl/core_pkg.sv
// Shared fetch-path types: widths, reset PC, queue entry and a pointer-width helper.
package core_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; (1 << i) < v; i++) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue of {pc, instr} entries; flush wins over push, read/write pointers carry a wrap MSB.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  fetch_entry_t            wr_entry,
  output fetch_entry_t            head,
  output logic [clog2(DEPTH):0]   count,
  output logic                    full,
  output logic                    empty
);
  localparam int AW = clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW:0]     wptr, rptr;
  logic            do_push, do_pop;

  assign count   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Idle head reads as zero so decode never sees a stale entry.
  assign head    = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr[AW-1:0]] <= wr_entry;
  end
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: in-order imem requests under a queue-credit limit, redirect flush with stale-response drop.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect raises fetch_fault and halts fetch until an aligned redirect.
module fetch_unit
  import core_pkg::*;
#(
  parameter int              XLEN            = core_pkg::XLEN,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = core_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr_data,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            fetch_fault
`endif
);
  localparam int OW = clog2(MAX_OUTSTANDING + 1);
  localparam int FW = clog2(FIFO_DEPTH) + 1;
  localparam int CW = clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);

  logic [XLEN-1:0] fetch_pc, rsp_pc, target;
  logic [OW-1:0]   outstanding, outstanding_nxt, drop;
  logic [FW-1:0]   count;
  logic [CW-1:0]   credit;
  logic            req_fire, rsp_live, push, pop, empty, full, fault;
  fetch_entry_t    head, wr_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target = redirect_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              fault <= 1'b0;
    else if (redirect_valid) fault <= |redirect_pc[1:0];
  end
  assign fetch_fault = fault;
`else
  assign target = redirect_pc & ~XLEN'(3);
  assign fault  = 1'b0;
`endif

  // Live in-flight responses each hold a reserved queue slot.
  assign credit          = CW'(count) + CW'(outstanding) - CW'(drop);
  assign imem_req_valid  = rst_n && !redirect_valid && !fault &&
                           (outstanding < OW'(MAX_OUTSTANDING)) && (credit < CW'(FIFO_DEPTH));
  assign imem_req_addr   = fetch_pc;
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign outstanding_nxt = outstanding + OW'(req_fire) - OW'(imem_rsp_valid);
  assign rsp_live        = imem_rsp_valid && (drop == '0);
  assign push            = rsp_live && !redirect_valid;
  assign pop             = instr_valid && instr_ready;

  assign wr_entry.pc    = rsp_pc;
  assign wr_entry.instr = imem_rsp_data;
  assign instr_valid    = !empty && !fault;
  assign instr_data     = head.instr;
  assign instr_pc       = head.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the old path.
        fetch_pc <= target;
        rsp_pc   <= target;
        drop     <= outstanding_nxt;
      end else begin
        if (req_fire)                          fetch_pc <= fetch_pc + XLEN'(4);
        if (imem_rsp_valid && (drop != '0))    drop     <= drop - 1'b1;
        if (push)                              rsp_pc   <= rsp_pc + XLEN'(4);
      end
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: latency-modelled imem plus an architectural PC-stream reference.
module tb_fetch_unit;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_data, instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
`ifdef FETCH_MISALIGN_TRAP_EN
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
`else
    .redirect_pc    (redirect_pc)
`endif
  );
`ifndef FETCH_MISALIGN_TRAP_EN
  assign fetch_fault = 1'b0;
`endif

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       mq[$];
  int          checks, errors, cyc, last_due, lat_lo, lat_hi, npops, nacc;
  int          pop_cyc[4];
  logic [31:0] exp_pc, exp_fetch, first_pop_pc, first_acc_addr, stall_addr;
  bit          stalled, ok;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    mq.delete();
    last_due = -1; stalled = 1'b0; exp_pc = '0; exp_fetch = '0; npops = 0; nacc = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr_data", instr_data, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  // One clock: drive inputs, let logic settle, score the handshakes that will fire on the edge.
  task automatic step(input bit rr, input bit ir, input bit rv, input logic [31:0] rpc);
    mreq_t m;
    int    due;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      m = mq.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(m.addr);
    end
    imem_req_ready = rr; instr_ready = ir; redirect_valid = rv; redirect_pc = rpc;
    #1;
    if (rv) check("redirect_noreq", 32'(imem_req_valid), 32'd0);
    if (stalled && !rv) begin
      check("stall_valid", 32'(imem_req_valid), 32'd1);
      check("stall_addr", imem_req_addr, stall_addr);
    end
    stalled    = imem_req_valid && !rr;
    stall_addr = imem_req_addr;
    if (imem_req_valid && rr) begin
      check("req_addr", imem_req_addr, exp_fetch);
      exp_fetch += 32'd4;
      due = cyc + int'($urandom_range(lat_lo, lat_hi));
      if (due <= last_due) due = last_due + 1;
      mq.push_back('{imem_req_addr, due});
      last_due = due;
      if (nacc == 0) first_acc_addr = imem_req_addr;
      nacc++;
    end
    if (instr_valid && ir) begin
      check("pop_pc", instr_pc, exp_pc);
      check("pop_data", instr_data, memf(instr_pc));
      exp_pc += 32'd4;
      if (npops == 0) first_pop_pc = instr_pc;
      if (npops < 4) pop_cyc[npops] = cyc;
      npops++;
    end
    if (rv) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      exp_fetch = rpc;
      exp_pc    = rpc;
`else
      exp_fetch = rpc & ~32'd3;
      exp_pc    = rpc & ~32'd3;
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to_pop(input string tag, input logic [31:0] exp);
    npops = 0;
    for (int i = 0; i < 40 && npops == 0; i++) step(1'b1, 1'b1, 1'b0, '0);
    check({tag, "_popped"}, 32'(npops != 0), 32'd1);
    check(tag, first_pop_pc, exp);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; lat_lo = 1; lat_hi = 1;
    #1;

    // Streaming at 1-cycle latency: first word two cycles after release, then one per cycle.
    do_reset();
    lat_lo = 1; lat_hi = 1;
    repeat (12) step(1'b1, 1'b1, 1'b0, '0);
    check("t1_first_pop_cyc", 32'(pop_cyc[0]), 32'd2);
    check("t1_fourth_pop_cyc", 32'(pop_cyc[3]), 32'd5);
    check("t1_npops", 32'(npops), 32'd10);

    // Decode stalled: exactly DEPTH fetched, fetch idles, then drains in order and resumes at 0x10.
    do_reset();
    repeat (20) step(1'b1, 1'b0, 1'b0, '0);
    check("t2_accepted", 32'(nacc), 32'd4);
    check("t2_inflight", 32'(mq.size()), 32'd0);
    check("t2_req_idle", 32'(imem_req_valid), 32'd0);
    check("t2_head_valid", 32'(instr_valid), 32'd1);
    nacc = 0; npops = 0;
    repeat (4) step(1'b1, 1'b1, 1'b0, '0);
    check("t2_drain", 32'(npops), 32'd4);
    check("t2_drain_span", 32'(pop_cyc[3] - pop_cyc[0]), 32'd3);
    repeat (4) step(1'b1, 1'b1, 1'b0, '0);
    check("t2_resumed", 32'(nacc != 0), 32'd1);
    check("t2_resume_addr", first_acc_addr, 32'h10);

    // Redirect with two requests in flight at latency 3.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (mq.size() == 2 && mq[0].due > cyc) ok = 1'b1;
      else step(1'b1, 1'b1, 1'b0, '0);
    end
    check("t3_two_inflight", 32'(ok), 32'd1);
    step(1'b1, 1'b1, 1'b1, 32'h100);
    run_to_pop("t3_first_pc", 32'h100);

    // Redirect in the same cycle a response lands.
    do_reset();
    lat_lo = 2; lat_hi = 2;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (nacc >= 2 && mq.size() > 0 && mq[0].due == cyc) ok = 1'b1;
      else step(1'b1, 1'b1, 1'b0, '0);
    end
    check("t4_rsp_aligned", 32'(ok), 32'd1);
    step(1'b1, 1'b1, 1'b1, 32'h40);
    run_to_pop("t4_first_pc", 32'h40);

    // Back-to-back redirects, then random ready/latency/redirect traffic.
    do_reset();
    lat_lo = 1; lat_hi = 4;
    repeat (8) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 32'h300);
    step(1'b1, 1'b1, 1'b1, 32'h380);
    run_to_pop("t5_last_redirect", 32'h380);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0),
           32'($urandom_range(0, 1023)) << 2);
    npops = 0;
    repeat (40) step(1'b1, 1'b1, 1'b0, '0);
    check("t5_drain_progress", 32'(npops >= 20), 32'd1);

    // Misaligned redirect target.
    do_reset();
    lat_lo = 1; lat_hi = 2;
    repeat (6) step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      check("t6_fault", 32'(fetch_fault), 32'd1);
      check("t6_no_req", 32'(imem_req_valid), 32'd0);
      check("t6_no_instr", 32'(instr_valid), 32'd0);
      step(1'b1, 1'b1, 1'b0, '0);
    end
    step(1'b1, 1'b1, 1'b1, 32'h200);
    check("t6_fault_clear", 32'(fetch_fault), 32'd0);
    run_to_pop("t6_first_pc", 32'h200);
`else
    run_to_pop("t6_first_pc", 32'h100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog got timeout exp finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
